// File: rtl/wb_result_fifo.sv
// In-order result buffer between an execution unit's writeback port and the core writeback stage.
// Optional WB_RESULT_FIFO_BYPASS_EN forwards a result straight through when the buffer is empty.
module wb_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     gc_flush,
    input  logic                     unit_done,
    input  logic [DATA_W-1:0]        unit_rd,
    input  logic [ID_W-1:0]          unit_id,
    output logic                     unit_ack,
    output logic                     wb_done,
    output logic [DATA_W-1:0]        wb_rd,
    output logic [ID_W-1:0]          wb_id,
    input  logic                     wb_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] rd;
        logic [ID_W-1:0]   id;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] stall_cnt;
    logic          full, empty, push, pop, byp, wr_en, rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // unit_ack never looks at wb_ack, so the unit side has no combinational path from writeback
    assign push     = unit_done & ~full & ~gc_flush & ~rst;
    assign unit_ack = push;

`ifdef WB_RESULT_FIFO_BYPASS_EN
    assign byp     = empty & unit_done & wb_ack & ~gc_flush;
    assign wb_done = ~rst & ~gc_flush & (~empty | unit_done);
    assign wb_rd   = empty ? unit_rd : mem[rd_ptr].rd;
    assign wb_id   = empty ? unit_id : mem[rd_ptr].id;
`else
    assign byp     = 1'b0;
    assign wb_done = ~empty;
    assign wb_rd   = mem[rd_ptr].rd;
    assign wb_id   = mem[rd_ptr].id;
`endif

    assign pop   = wb_ack & wb_done & ~gc_flush;
    // a forwarded result consumes neither a slot nor a read
    assign wr_en = push & ~byp;
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= '{rd: unit_rd, id: unit_id};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (gc_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // stall_cnt saturates at DEPTH; one more blocked cycle means writeback is deadlocked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt    <= '0;
            overflow_err <= 1'b0;
        end else if (unit_done & full) begin
            if (stall_cnt == CW'(DEPTH)) overflow_err <= 1'b1;
            else                         stall_cnt    <= stall_cnt + 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_wb_result_fifo.sv
// Randomized self-checking bench for wb_result_fifo against a queue-based reference model.
// Honors WB_RESULT_FIFO_BYPASS_EN in the model the same way the design does.
module tb_wb_result_fifo;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        ack;
        logic        done;
        logic [31:0] rd;
        logic [2:0]  id;
        logic [2:0]  count;
        logic        ovf;
    } obs_t;

    typedef struct packed {
        logic [31:0] rd;
        logic [2:0]  id;
    } ent_t;

    logic        clk = 1'b0, rst = 1'b0, gc_flush = 1'b0;
    logic        unit_done = 1'b0, wb_ack = 1'b0;
    logic [31:0] unit_rd = '0;
    logic [2:0]  unit_id = '0;
    logic        unit_ack, wb_done, overflow_err;
    logic [31:0] wb_rd;
    logic [2:0]  wb_id, count;

    int   checks = 0, passes = 0, cyc_n = 0;
    ent_t mq[$];
    int   m_run = 0;
    logic m_ovf = 1'b0;
    ent_t src[$], sent[$], got[$];

    wb_result_fifo #(.DEPTH(DEPTH), .DATA_W(32), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .gc_flush(gc_flush),
        .unit_done(unit_done), .unit_rd(unit_rd), .unit_id(unit_id), .unit_ack(unit_ack),
        .wb_done(wb_done), .wb_rd(wb_rd), .wb_id(wb_id), .wb_ack(wb_ack),
        .count(count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic string fmt(obs_t x);
        return $sformatf("ack=%b done=%b rd=%h id=%0d cnt=%0d ovf=%b",
                         x.ack, x.done, x.rd, x.id, x.count, x.ovf);
    endfunction

    function automatic bit same_q();
        if (got.size() != sent.size()) return 1'b0;
        foreach (got[k]) if (got[k] !== sent[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_run = 0;
        m_ovf = 1'b0;
    endfunction

    // One clock: drive inputs, sample outputs, predict them from the model, then advance the model.
    task automatic cyc(input logic d, input logic [31:0] r, input logic [2:0] i,
                       input logic a, input logic f, output obs_t o, output obs_t e);
        int sz;
        bit byp;
        unit_done = d; unit_rd = r; unit_id = i; wb_ack = a; gc_flush = f;
        #2;
        o = '{unit_ack, wb_done, wb_rd, wb_id, count, overflow_err};
        sz = mq.size();
        e = '0;
        e.ack = d && (sz < DEPTH) && !f;
`ifdef WB_RESULT_FIFO_BYPASS_EN
        e.done = !f && (sz > 0 || d);
        if (sz > 0) begin e.rd = mq[0].rd; e.id = mq[0].id; end
        else begin e.rd = r; e.id = i; end
`else
        e.done = (sz > 0);
        if (sz > 0) begin e.rd = mq[0].rd; e.id = mq[0].id; end
`endif
        e.count = 3'(sz);
        e.ovf   = m_ovf;
        if (!e.done) begin o.rd = '0; o.id = '0; e.rd = '0; e.id = '0; end
        @(posedge clk);
        if (d && sz == DEPTH) m_run++; else m_run = 0;
        if (m_run > DEPTH) m_ovf = 1'b1;
        if (f) mq.delete();
        else begin
            byp = 1'b0;
`ifdef WB_RESULT_FIFO_BYPASS_EN
            byp = (sz == 0) && d && a;
`endif
            if (!byp) begin
                if (a && sz > 0) void'(mq.pop_front());
                if (e.ack) mq.push_back('{rd: r, id: i});
            end
        end
        cyc_n++;
        #1;
    endtask

    // Unit that holds its head request until acked; records what writeback consumes.
    task automatic ustep(input logic a, input logic f, output obs_t o, output obs_t e);
        ent_t s;
        logic d;
        d = (src.size() > 0);
        s = d ? src[0] : '0;
        cyc(d, s.rd, s.id, a, f, o, e);
        if (o.ack && src.size() > 0) void'(src.pop_front());
        if (o.done && a && !f) got.push_back('{rd: o.rd, id: o.id});
    endtask

    task automatic load(input int n, input int id0);
        ent_t x;
        for (int k = 0; k < n; k++) begin
            x.rd = $urandom;
            x.id = 3'((id0 + k) % 8);
            src.push_back(x);
            sent.push_back(x);
        end
    endtask

    task automatic fresh();
        src.delete(); sent.delete(); got.delete();
    endtask

    task automatic test_reset();
        unit_done = 1'b1; wb_ack = 1'b1; gc_flush = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (unit_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", unit_ack); else passes++;
        checks++; if (wb_done !== 1'b0) $display("FAIL reset_done: got %b want 0", wb_done); else passes++;
        checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passes++;
        checks++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_err); else passes++;
        @(posedge clk); #1;
        rst = 1'b0; unit_done = 1'b0; wb_ack = 1'b0;
        model_clear();
    endtask

    task automatic test_single();
        obs_t o, e;
        fresh();
        src.push_back('{rd: 32'h0000_1234, id: 3'd2});
        sent.push_back('{rd: 32'h0000_1234, id: 3'd2});
        for (int k = 0; k < 3; k++) begin
            ustep(1'b1, 1'b0, o, e);
            if (k == 0) begin
                checks++; if (o.ack !== 1'b1) $display("FAIL single_ack0: got %b want 1", o.ack); else passes++;
            end
            checks++; if (o !== e) $display("FAIL single c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
        checks++; if (count !== 3'd0) $display("FAIL single_empty: got cnt=%0d want 0", count); else passes++;
        checks++; if (!same_q()) $display("FAIL single_order: got %0d results want %0d", got.size(), sent.size()); else passes++;
    endtask

    task automatic test_fill();
        obs_t o, e;
        fresh();
        load(5, 0);
        for (int k = 0; k < 5; k++) begin
            ustep(1'b0, 1'b0, o, e);
            checks++; if (o !== e) $display("FAIL fill c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
        checks++; if (o.ack !== 1'b0 || o.count !== 3'd4) $display("FAIL fill_full: got ack=%b cnt=%0d want ack=0 cnt=4", o.ack, o.count); else passes++;
        for (int k = 0; k < 12 && got.size() < 5; k++) begin
            ustep(1'b1, 1'b0, o, e);
            checks++; if (o !== e) $display("FAIL fill_drain c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
        checks++; if (!same_q()) $display("FAIL fill_order: got %0d results want %0d in order", got.size(), sent.size()); else passes++;
    endtask

    task automatic test_full_simul();
        obs_t o, e;
        fresh();
        load(5, 3);
        for (int k = 0; k < 5; k++) ustep(1'b0, 1'b0, o, e);
        ustep(1'b1, 1'b0, o, e);
        checks++; if (o !== e) $display("FAIL simul_pulse: got %s want %s", fmt(o), fmt(e)); else passes++;
        ustep(1'b0, 1'b0, o, e);
        checks++; if (o.count !== 3'd3 || o.ack !== 1'b1) $display("FAIL simul_cnt3: got cnt=%0d ack=%b want cnt=3 ack=1", o.count, o.ack); else passes++;
        ustep(1'b0, 1'b0, o, e);
        checks++; if (o.count !== 3'd4) $display("FAIL simul_cnt4: got cnt=%0d want 4", o.count); else passes++;
        for (int k = 0; k < 12 && got.size() < 5; k++) begin
            ustep(1'b1, 1'b0, o, e);
            checks++; if (o !== e) $display("FAIL simul_drain c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
        checks++; if (!same_q()) $display("FAIL simul_order: got %0d results want %0d in order", got.size(), sent.size()); else passes++;
    endtask

    task automatic test_wrap();
        obs_t o, e;
        fresh();
        load(10, 1);
        for (int k = 0; k < 40 && got.size() < 10; k++) begin
            ustep(logic'(k % 2 == 0), 1'b0, o, e);
            checks++; if (o !== e) $display("FAIL wrap c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
        checks++; if (!same_q()) $display("FAIL wrap_order: got %0d results want %0d in order", got.size(), sent.size()); else passes++;
    endtask

    task automatic test_flush();
        obs_t o, e;
        fresh();
        load(4, 2);
        sent.delete();
        sent.push_back(src[3]);
        for (int k = 0; k < 3; k++) ustep(1'b0, 1'b0, o, e);
        ustep(1'b0, 1'b1, o, e);
        checks++; if (o.ack !== 1'b0 || o.count !== 3'd3) $display("FAIL flush_cyc: got ack=%b cnt=%0d want ack=0 cnt=3", o.ack, o.count); else passes++;
        ustep(1'b0, 1'b0, o, e);
        checks++; if (o.count !== 3'd0) $display("FAIL flush_cnt: got cnt=%0d want 0", o.count); else passes++;
        checks++; if (o !== e) $display("FAIL flush_after: got %s want %s", fmt(o), fmt(e)); else passes++;
        for (int k = 0; k < 6 && got.size() < 1; k++) begin
            ustep(1'b1, 1'b0, o, e);
            checks++; if (o !== e) $display("FAIL flush_drain c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
        checks++; if (!same_q()) $display("FAIL flush_order: got %0d results want held one only", got.size()); else passes++;
    endtask

    task automatic test_overflow();
        obs_t o, e;
        fresh();
        load(5, 4);
        for (int k = 0; k < 2 * DEPTH + 3; k++) begin
            ustep(1'b0, 1'b0, o, e);
            checks++; if (o !== e) $display("FAIL ovf c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
        checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_err); else passes++;
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        got.delete();
        sent.delete();
        sent.push_back(src[0]);
        unit_done = 1'b1; unit_rd = src[0].rd; unit_id = src[0].id; wb_ack = 1'b0; gc_flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (wb_done !== 1'b0 || count !== 3'd0) $display("FAIL areset_now: got done=%b cnt=%0d want 0 0", wb_done, count); else passes++;
        checks++; if (overflow_err !== 1'b0 || unit_ack !== 1'b0) $display("FAIL areset_ovf: got ovf=%b ack=%b want 0 0", overflow_err, unit_ack); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 6 && got.size() < 1; k++) begin
            ustep(1'b1, 1'b0, o, e);
            checks++; if (o !== e) $display("FAIL areset_resume c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
        checks++; if (!same_q()) $display("FAIL areset_order: got %0d results want 1", got.size()); else passes++;
    endtask

    task automatic test_random();
        obs_t o, e;
        fresh();
        for (int k = 0; k < 300; k++) begin
            if (src.size() == 0 && $urandom_range(2) != 0) load(1, $urandom_range(7));
            ustep(logic'($urandom_range(1)), logic'($urandom_range(15) == 0), o, e);
            checks++; if (o !== e) $display("FAIL random c%0d: got %s want %s", k, fmt(o), fmt(e)); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_simul();
        test_wrap();
        test_flush();
        test_overflow();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
